// File: rtl/step_fsm_param.sv
// rtl/step_fsm_param.sv - parametrised step FSM: preset/load, sat/wrap add-sub, multi-cycle shifts, rotate
module step_fsm_param #(
   parameter int          WIDTH    = 12,
   parameter int          STEP_W   = 4,
   parameter int unsigned PRESET   = 12'h588,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [2:0]        op,
   input  logic [STEP_W-1:0] value,
   output logic [WIDTH-1:0]  outputValue,
   output logic              busy,
   output logic              overflow,
   output logic              underflow,
   output logic              zero
);

   localparam logic [2:0] OP_HOLD       = 3'b000;
   localparam logic [2:0] OP_LOAD_PRE   = 3'b001;
   localparam logic [2:0] OP_SUB        = 3'b010;
   localparam logic [2:0] OP_ADD        = 3'b011;
   localparam logic [2:0] OP_SHR_N      = 3'b100;
   localparam logic [2:0] OP_SHL_N      = 3'b101;
   localparam logic [2:0] OP_ROR1       = 3'b110;
   localparam logic [2:0] OP_LOAD_VALUE = 3'b111;

   // Shift sequencer: idle, or which direction the pending shift bits go
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SHL  = 2'd1;
   localparam logic [1:0] S_SHR  = 2'd2;

   localparam logic [WIDTH-1:0] PRESET_V = WIDTH'(PRESET);

   logic [WIDTH-1:0]  state;
   logic [1:0]        mode;
   logic [STEP_W-1:0] count;
   logic [WIDTH-1:0]  value_ext;
   logic [WIDTH:0]    sum;
   logic [WIDTH:0]    diff;

   assign value_ext   = {{(WIDTH-STEP_W){1'b0}}, value};
   // The extra top bit is the carry of the add and the borrow of the subtract
   assign sum         = {1'b0, state} + {1'b0, value_ext};
   assign diff        = {1'b0, state} - {1'b0, value_ext};

   assign outputValue = state;
   assign busy        = (count != '0);
   assign zero        = (state == '0);

   // Command execution, and one bit per edge of any shift still pending
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= '0;
         mode      <= S_IDLE;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (busy) begin
         if (mode == S_SHL) begin
            state <= state << 1;
            if (state[WIDTH-1]) overflow <= 1'b1;
         end else begin
            state <= state >> 1;
         end
         count <= count - 1'b1;
         if (count == STEP_W'(1)) mode <= S_IDLE;
      end else if (enable) begin
         case (op)
            OP_HOLD: ;
            OP_LOAD_PRE: begin
               state     <= PRESET_V;
               overflow  <= 1'b0;
               underflow <= 1'b0;
            end
            OP_SUB: begin
               if (diff[WIDTH]) begin
                  underflow <= 1'b1;
                  state     <= SATURATE ? '0 : diff[WIDTH-1:0];
               end else begin
                  state <= diff[WIDTH-1:0];
               end
            end
            OP_ADD: begin
               if (sum[WIDTH]) begin
                  overflow <= 1'b1;
                  state    <= SATURATE ? '1 : sum[WIDTH-1:0];
               end else begin
                  state <= sum[WIDTH-1:0];
               end
            end
            OP_SHR_N: begin
               // The accepting edge already performs the first of N shifts
               if (value != '0) begin
                  state <= state >> 1;
                  count <= value - 1'b1;
                  mode  <= (value == STEP_W'(1)) ? S_IDLE : S_SHR;
               end
            end
            OP_SHL_N: begin
               if (value != '0) begin
                  state <= state << 1;
                  if (state[WIDTH-1]) overflow <= 1'b1;
                  count <= value - 1'b1;
                  mode  <= (value == STEP_W'(1)) ? S_IDLE : S_SHL;
               end
            end
            OP_ROR1:       state <= {state[0], state[WIDTH-1:1]};
            OP_LOAD_VALUE: state <= value_ext;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_step_fsm_param.sv
// tb/tb_step_fsm_param.sv - randomized bench with a behavioural model for step_fsm_param (saturating and wrapping)
module tb_step_fsm_param;

   localparam int W    = 12;
   localparam int MASK = 12'hFFF;

   logic        clock  = 1'b0;
   logic        reset  = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  op     = 3'd0;
   logic [3:0]  value  = 4'd0;

   logic [11:0] out_s, out_w;
   logic        busy_s, busy_w, ovf_s, ovf_w, unf_s, unf_w, zero_s, zero_w;

   int n_cmp = 0;
   int n_err = 0;

   // Model: index 0 = saturating instance, 1 = wrapping instance
   int m_val[2]  = '{0, 0};
   bit m_ovf[2]  = '{0, 0};
   bit m_unf[2]  = '{0, 0};
   int m_orig[2] = '{0, 0};
   int m_rem     = 0;
   int m_k       = 0;
   bit m_left    = 1'b0;

   step_fsm_param #(.WIDTH(12), .STEP_W(4), .PRESET(12'h588), .SATURATE(1'b1)) dut_sat (
      .clock(clock), .reset(reset), .enable(enable), .op(op), .value(value),
      .outputValue(out_s), .busy(busy_s), .overflow(ovf_s), .underflow(unf_s), .zero(zero_s));

   step_fsm_param #(.WIDTH(12), .STEP_W(4), .PRESET(12'h588), .SATURATE(1'b0)) dut_wrap (
      .clock(clock), .reset(reset), .enable(enable), .op(op), .value(value),
      .outputValue(out_w), .busy(busy_w), .overflow(ovf_w), .underflow(unf_w), .zero(zero_w));

   initial forever #5 clock = ~clock;

   function automatic int shifted(int orig, int k, bit left);
      if (k >= W) return 0;
      return left ? ((orig << k) & MASK) : (orig >> k);
   endfunction

   function automatic bit lost_ones(int orig, int k);
      longint x;
      x = longint'(orig) << k;
      return (x >> W) != 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model reset: immediate, independent of the clock
   always @(negedge reset) begin
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end
      m_rem = 0;
      m_k   = 0;
   end

   // Model step: the total shift state after k edges is orig shifted by k
   always @(posedge clock) begin
      if (reset) begin
         if (m_rem > 0) begin
            m_k++;
            m_rem--;
            for (int i = 0; i < 2; i++) begin
               m_val[i] = shifted(m_orig[i], m_k, m_left);
               if (m_left && lost_ones(m_orig[i], m_k)) m_ovf[i] = 1;
            end
         end else if (enable) begin
            for (int i = 0; i < 2; i++) begin
               int v;
               int s;
               v = int'(value);
               case (op)
                  3'd1: begin m_val[i] = 12'h588; m_ovf[i] = 0; m_unf[i] = 0; end
                  3'd2: begin
                     if (v > m_val[i]) begin
                        m_unf[i] = 1;
                        m_val[i] = (i == 0) ? 0 : ((m_val[i] + 4096 - v) & MASK);
                     end else m_val[i] = m_val[i] - v;
                  end
                  3'd3: begin
                     s = m_val[i] + v;
                     if (s > MASK) begin
                        m_ovf[i] = 1;
                        m_val[i] = (i == 0) ? MASK : (s & MASK);
                     end else m_val[i] = s;
                  end
                  3'd4, 3'd5: begin
                     if (v != 0) begin
                        m_left    = (op == 3'd5);
                        m_orig[i] = m_val[i];
                        m_k       = 1;
                        m_rem     = v - 1;
                        m_val[i]  = shifted(m_orig[i], 1, m_left);
                        if (m_left && lost_ones(m_orig[i], 1)) m_ovf[i] = 1;
                     end
                  end
                  3'd6: m_val[i] = (m_val[i] >> 1) | ((m_val[i] & 1) << (W - 1));
                  3'd7: m_val[i] = v;
                  default: ;
               endcase
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge clock) begin
      check("sat value",     int'(out_s),  m_val[0]);
      check("sat busy",      int'(busy_s), int'(m_rem > 0));
      check("sat overflow",  int'(ovf_s),  int'(m_ovf[0]));
      check("sat underflow", int'(unf_s),  int'(m_unf[0]));
      check("sat zero",      int'(zero_s), int'(m_val[0] == 0));
      check("wrap value",    int'(out_w),  m_val[1]);
      check("wrap busy",     int'(busy_w), int'(m_rem > 0));
      check("wrap overflow", int'(ovf_w),  int'(m_ovf[1]));
      check("wrap underflow",int'(unf_w),  int'(m_unf[1]));
      check("wrap zero",     int'(zero_w), int'(m_val[1] == 0));
   end

   task automatic cmd(input logic [2:0] o, input logic [3:0] v);
      enable = 1'b1; op = o; value = v;
      @(posedge clock); #1;
      enable = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy_s && t < 40) begin
         @(posedge clock); #1;
         t++;
      end
      check("idle timeout", int'(busy_s), 0);
   endtask

   task automatic shl(input logic [3:0] n);
      cmd(3'd5, n);
      wait_idle();
   endtask

   task automatic build_fff();
      cmd(3'd7, 4'hF); shl(4'd4); cmd(3'd3, 4'hF); shl(4'd4); cmd(3'd3, 4'hF);
   endtask

   initial begin
      #12 reset = 1'b1;
      @(posedge clock); #1;
      check("reset value", int'(out_s), 0);
      check("reset zero", int'(zero_s), 1);
      check("reset flags", int'({ovf_s, unf_s, busy_s}), 0);

      cmd(3'd1, 4'd0);
      check("preset", int'(out_s), 12'h588);
      check("preset zero", int'(zero_s), 0);
      cmd(3'd3, 4'hF);
      check("add 0xF", int'(out_w), 12'h597);
      check("model add", m_val[0], 12'h597);

      cmd(3'd7, 4'd3); cmd(3'd2, 4'd5);
      check("sub sat", int'(out_s), 0);
      check("sub sat unf", int'(unf_s), 1);
      check("sub wrap", int'(out_w), 12'hFFE);
      check("model sub wrap", m_val[1], 12'hFFE);
      check("sub wrap unf", int'(unf_w), 1);

      cmd(3'd7, 4'hF); shl(4'd4); cmd(3'd3, 4'hF); shl(4'd4); cmd(3'd3, 4'hC);
      check("build FFC", int'(out_s), 12'hFFC);
      cmd(3'd3, 4'd7);
      check("add sat", int'(out_s), 12'hFFF);
      check("add sat ovf", int'(ovf_s), 1);
      check("add wrap", int'(out_w), 12'h003);
      check("add wrap ovf", int'(ovf_w), 1);
      cmd(3'd1, 4'd0);
      check("preset clears ovf", int'(ovf_s), 0);
      check("preset after ovf", int'(out_s), 12'h588);

      // SHL by 3 with an ADD pulsed while busy
      enable = 1'b1; op = 3'd5; value = 4'd3;
      @(posedge clock); #1;
      check("shl busy 1", int'(busy_s), 1);
      check("shl step 1", int'(out_s), 12'hB10);
      op = 3'd3; value = 4'd5;
      @(posedge clock); #1;
      enable = 1'b0;
      check("shl busy 2", int'(busy_s), 1);
      check("shl step 2", int'(out_s), 12'h620);
      @(posedge clock); #1;
      check("shl done busy", int'(busy_s), 0);
      check("shl result", int'(out_s), 12'hC40);
      check("shl ovf", int'(ovf_s), 1);

      // Asynchronous reset in the middle of SHR by 9
      build_fff();
      check("build FFF", int'(out_s), 12'hFFF);
      enable = 1'b1; op = 3'd4; value = 4'd9;
      @(posedge clock); #1;
      enable = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("shr 3 edges", int'(out_s), 12'h1FF);
      check("shr mid busy", int'(busy_s), 1);
      #2 reset = 1'b0;
      #1;
      check("async rst value", int'(out_s), 0);
      check("async rst busy", int'(busy_s), 0);
      check("async rst flags", int'({ovf_s, unf_s}), 0);
      #4 reset = 1'b1;
      cmd(3'd0, 4'd0);
      check("hold after rst", int'(out_s), 0);

      // Disabled commands, SHR by 0, and ROR1
      cmd(3'd7, 4'd6);
      enable = 1'b0; op = 3'd3; value = 4'd5;
      repeat (10) @(posedge clock);
      #1;
      check("enable low", int'(out_s), 6);
      enable = 1'b1; op = 3'd4; value = 4'd0;
      @(posedge clock); #1;
      enable = 1'b0;
      check("shr0 busy", int'(busy_s), 0);
      check("shr0 value", int'(out_s), 6);
      cmd(3'd7, 4'd1); cmd(3'd6, 4'd0);
      check("ror1", int'(out_s), 12'h800);
      check("ror1 wrap", int'(out_w), 12'h800);

      // Randomized traffic with occasional asynchronous reset pulses
      repeat (700) begin
         enable = 1'($urandom_range(0, 1));
         op     = 3'($urandom_range(0, 7));
         value  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 80) == 0) begin
            #1 reset = 1'b0;
            #2 reset = 1'b1;
         end
         @(posedge clock); #1;
      end
      enable = 1'b0;
      @(negedge clock);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
